// File: rtl/nrisc_pkg.sv
// nrisc_pkg
// Shared types and constants for the 8-bit nRISC core front end.
//   INST_W / ADDR_W   : instruction and address widths
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   fetch_state_t     : fetch stage state (RUN, FLUSH)
//   fetch_entry_t     : one prefetch queue record {pc, inst}
package nrisc_pkg;

    localparam int INST_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/nrisc_fetch_fifo.sv
// nrisc_fetch_fifo
// Synchronous DEPTH-entry prefetch queue of {pc, inst} records.
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   clear           : drop every entry this cycle (wins over push/pop)
//   push, push_entry: write a record at the tail
//   pop             : remove the head (ignored when empty)
//   head            : head record, all zeros when the queue is empty
//   count           : current occupancy, 0..DEPTH
module nrisc_fetch_fifo
    import nrisc_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [PW:0]  count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count_q;
    logic          do_pop;

    // A pop on an empty queue must not move the read pointer.
    assign do_pop = pop && (count_q != '0);

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= push_entry;
    end

    assign head  = (count_q != '0) ? mem[rd_ptr] : '0;
    assign count = count_q;

endmodule

// File: rtl/nrisc_fetch.sv
// nrisc_fetch
// Instruction fetch stage: owns the PC, reads the synchronous instruction
// memory, buffers {pc, inst} in a prefetch queue and hands them to decode.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   fetch_en              : allows new memory reads (queue still drains when 0)
//   imem_rd_en, imem_addr : read strobe and address to instruction memory
//   imem_data             : read data, valid the cycle after an accepted read
//   redirect, redirect_pc : taken branch/jump, flush and restart at redirect_pc
//   inst_valid/data/pc    : queue head towards decode
//   inst_ready            : decode accepts the head this cycle
module nrisc_fetch
    import nrisc_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_STEP  = 8'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CW:0]       fifo_count;
    logic [CW:0]       occupancy;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FLUSH covers exactly the cycle after a redirect; repeated redirects keep it there.
    always_comb begin
        state_d = RUN;
        if (redirect) state_d = FLUSH;
    end

    // Issue, push and pop strobes. Counting the in-flight read in the occupancy
    // guarantees the response always finds a free slot. A response in FLUSH is
    // stale, and a response coinciding with a redirect would land in a queue
    // that is being cleared, so both are dropped.
    always_comb begin
        occupancy = fifo_count + {{CW{1'b0}}, inflight_q};
        issue     = fetch_en && !redirect && !reset && (occupancy < DEPTH_C);
        push      = inflight_q && !redirect && (state_q == RUN);
        pop       = inst_valid && inst_ready && !redirect;
    end

    // Fetch PC and in-flight tracking; the PC of each read rides alongside it
    // so the returning instruction can be tagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + PC_STEP;
            end
        end
    end

    assign push_entry = '{pc: inflight_pc_q, inst: imem_data};

    nrisc_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .clear      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign imem_rd_en = issue;
    assign imem_addr  = pc_q;
    assign inst_valid = (fifo_count != '0);
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_nrisc_fetch.sv
// tb_nrisc_fetch
// Bench for nrisc_fetch: a directed vector table, hand-written corner
// sequences, and a randomized run checked against a queue-based model.
module tb_nrisc_fetch;

    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic       fetch_en;
    logic       imem_rd_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       inst_valid;
    logic [7:0] inst_data;
    logic [7:0] inst_pc;
    logic       inst_ready;

    int n_checks;
    int n_fail;

    nrisc_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00),
        .PC_STEP  (8'd1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction memory: contents are addr + 8'h10.
    function automatic logic [7:0] mem_val(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    always @(posedge clock) begin
        if (imem_rd_en) imem_data <= mem_val(imem_addr);
    end

    typedef struct {
        bit         fe;
        bit         rdy;
        bit         rdr;
        logic [7:0] rpc;
        bit         exp_rd;
        logic [7:0] exp_addr;
        bit         exp_valid;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t tbl [18];

    typedef struct {
        logic [7:0] pc;
        int         avail;
    } ment_t;

    ment_t      mq [$];
    logic [7:0] m_pc;
    int         m_cyc;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit fe, input bit rdy, input bit rdr, input logic [7:0] rpc);
        @(negedge clock);
        fetch_en    = fe;
        inst_ready  = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clock);
        reset       = 1'b1;
        fetch_en    = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        @(posedge clock);
        #1;
        if (chk) begin
            check_output("reset_rd_en", 8'(imem_rd_en), 8'h00);
            check_output("reset_addr",  imem_addr,      8'h00);
            check_output("reset_valid", 8'(inst_valid), 8'h00);
            check_output("reset_data",  inst_data,      8'h00);
            check_output("reset_pc",    inst_pc,        8'h00);
        end
        @(negedge clock);
        fetch_en = 1'b0;
        reset    = 1'b0;
    endtask

    // Reference model: a list of issued-but-undelivered PCs, each tagged with
    // the cycle it becomes visible at the head (two cycles after issue).
    task automatic model_reset();
        mq.delete();
        m_pc  = 8'h00;
        m_cyc = 0;
    endtask

    task automatic model_cycle(input bit fe, input bit rdy, input bit rdr, input logic [7:0] rpc);
        bit e_valid;
        bit e_rd;
        e_valid = (mq.size() > 0) && (mq[0].avail <= m_cyc);
        e_rd    = fe && !rdr && (mq.size() < DEPTH);
        check_output("rnd_rd_en", 8'(imem_rd_en), 8'(e_rd));
        check_output("rnd_addr",  imem_addr,      m_pc);
        check_output("rnd_valid", 8'(inst_valid), 8'(e_valid));
        if (e_valid) begin
            check_output("rnd_pc",   inst_pc,   mq[0].pc);
            check_output("rnd_data", inst_data, mem_val(mq[0].pc));
        end
        if (rdr) begin
            mq.delete();
            m_pc = rpc;
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (e_rd) begin
                mq.push_back('{pc: m_pc, avail: m_cyc + 2});
                m_pc = m_pc + 8'd1;
            end
        end
        m_cyc++;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        fetch_en    = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        imem_data   = 8'h00;

        // Straight-line, redirect with a read in flight, then wrap-around.
        tbl[0]  = '{1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00};
        tbl[1]  = '{1, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00};
        tbl[2]  = '{1, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00};
        tbl[3]  = '{1, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01};
        tbl[4]  = '{1, 1, 0, 8'h00, 1, 8'h04, 1, 8'h02};
        tbl[5]  = '{1, 1, 0, 8'h00, 1, 8'h05, 1, 8'h03};
        tbl[6]  = '{1, 1, 1, 8'h40, 0, 8'h00, 1, 8'h04};
        tbl[7]  = '{1, 1, 0, 8'h00, 1, 8'h40, 0, 8'h00};
        tbl[8]  = '{1, 1, 0, 8'h00, 1, 8'h41, 0, 8'h00};
        tbl[9]  = '{1, 1, 0, 8'h00, 1, 8'h42, 1, 8'h40};
        tbl[10] = '{1, 1, 0, 8'h00, 1, 8'h43, 1, 8'h41};
        tbl[11] = '{1, 1, 1, 8'hFE, 0, 8'h00, 1, 8'h42};
        tbl[12] = '{1, 1, 0, 8'h00, 1, 8'hFE, 0, 8'h00};
        tbl[13] = '{1, 1, 0, 8'h00, 1, 8'hFF, 0, 8'h00};
        tbl[14] = '{1, 1, 0, 8'h00, 1, 8'h00, 1, 8'hFE};
        tbl[15] = '{1, 1, 0, 8'h00, 1, 8'h01, 1, 8'hFF};
        tbl[16] = '{1, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00};
        tbl[17] = '{1, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01};

        do_reset(1'b1);
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(tbl[i].fe, tbl[i].rdy, tbl[i].rdr, tbl[i].rpc);
            check_output($sformatf("tbl%0d_rd_en", i), 8'(imem_rd_en), 8'(tbl[i].exp_rd));
            if (tbl[i].exp_rd)
                check_output($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            check_output($sformatf("tbl%0d_valid", i), 8'(inst_valid), 8'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check_output($sformatf("tbl%0d_pc", i),   inst_pc,   tbl[i].exp_pc);
                check_output($sformatf("tbl%0d_data", i), inst_data, mem_val(tbl[i].exp_pc));
            end
        end

        // Backpressure: four reads fill queue + in-flight slot, head holds at pc 00.
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            apply_stimulus(1, 0, 0, 8'h00);
            check_output($sformatf("bp%0d_rd_en", c), 8'(imem_rd_en), (c < 4) ? 8'h01 : 8'h00);
            if (c < 4) check_output($sformatf("bp%0d_addr", c), imem_addr, 8'(c));
            check_output($sformatf("bp%0d_valid", c), 8'(inst_valid), (c >= 2) ? 8'h01 : 8'h00);
            if (c >= 2) begin
                check_output($sformatf("bp%0d_pc", c),   inst_pc,   8'h00);
                check_output($sformatf("bp%0d_data", c), inst_data, 8'h10);
            end
        end
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1, 1, 0, 8'h00);
            if (c == 0) check_output("bp_rel_rd_en0", 8'(imem_rd_en), 8'h00);
            if (c == 1) begin
                check_output("bp_rel_rd_en1", 8'(imem_rd_en), 8'h01);
                check_output("bp_rel_addr1",  imem_addr,      8'h04);
            end
            check_output($sformatf("bp_rel%0d_valid", c), 8'(inst_valid), 8'h01);
            check_output($sformatf("bp_rel%0d_pc", c),    inst_pc,        8'(c));
            check_output($sformatf("bp_rel%0d_data", c),  inst_data,      mem_val(8'(c)));
        end

        // fetch_en drop with one read in flight.
        do_reset(1'b0);
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("fe_rd0", 8'(imem_rd_en), 8'h01);
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(0, 1, 0, 8'h00);
            check_output($sformatf("fe%0d_rd_en", k), 8'(imem_rd_en), 8'h00);
            check_output($sformatf("fe%0d_valid", k), 8'(inst_valid), (k == 2) ? 8'h01 : 8'h00);
            if (k == 2) begin
                check_output("fe_pc",   inst_pc,   8'h00);
                check_output("fe_data", inst_data, 8'h10);
            end
        end
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("fe_resume_rd", 8'(imem_rd_en), 8'h01);
        check_output("fe_resume_addr", imem_addr, 8'h01);
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("fe_resume_gap", 8'(inst_valid), 8'h00);
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("fe_resume_valid", 8'(inst_valid), 8'h01);
        check_output("fe_resume_pc",    inst_pc,        8'h01);
        check_output("fe_resume_data",  inst_data,      8'h11);

        // Asynchronous reset with three entries queued.
        do_reset(1'b0);
        for (int c = 0; c < 3; c++) apply_stimulus(1, 0, 0, 8'h00);
        apply_stimulus(0, 0, 0, 8'h00);
        apply_stimulus(0, 0, 0, 8'h00);
        check_output("ar_pre_valid", 8'(inst_valid), 8'h01);
        check_output("ar_pre_pc",    inst_pc,        8'h00);
        #2;
        reset    = 1'b1;
        fetch_en = 1'b1;
        #1;
        check_output("ar_valid_noedge", 8'(inst_valid), 8'h00);
        check_output("ar_rd_en_noedge", 8'(imem_rd_en), 8'h00);
        check_output("ar_addr_noedge",  imem_addr,      8'h00);
        @(negedge clock);
        reset    = 1'b0;
        fetch_en = 1'b0;
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("ar_post_rd",    8'(imem_rd_en), 8'h01);
        check_output("ar_post_addr",  imem_addr,      8'h00);
        check_output("ar_post_v0",    8'(inst_valid), 8'h00);
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("ar_post_v1",    8'(inst_valid), 8'h00);
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("ar_post_v2",    8'(inst_valid), 8'h01);
        check_output("ar_post_pc2",   inst_pc,        8'h00);
        check_output("ar_post_data2", inst_data,      8'h10);
        apply_stimulus(1, 1, 0, 8'h00);
        check_output("ar_post_pc3",   inst_pc,        8'h01);

        // Randomized run against the queue model.
        do_reset(1'b0);
        model_reset();
        for (int n = 0; n < 500; n++) begin
            bit         fe;
            bit         rdy;
            bit         rdr;
            logic [7:0] rpc;
            fe  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 7);
            rdr = ($urandom_range(0, 19) == 0);
            rpc = 8'($urandom_range(0, 255));
            apply_stimulus(fe, rdy, rdr, rpc);
            model_cycle(fe, rdy, rdr, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
